rs232_fifo_port: RTL and testbench

RS232_FIFO_PORT -- requirements
Module: rs232_fifo_port

---
 rtl/rs232_fifo_port.sv | 195 +++++++++++++++++++
 tb/tb_rs232_fifo_port.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_fifo_port.sv
// Memory-mapped RS232 port: RX/TX byte FIFOs, status/control registers,
// received-byte counter, free-running timestamp counter and a TX drain FSM.
module rs232_fifo_port #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4,
    parameter int TSC_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_a,
    input  logic        req_r,
    input  logic        req_w,
    input  logic [31:0] req_wd,
    output logic [31:0] res_rd,
    output logic        res_hold,
    input  logic        rs232in_attention,
    input  logic [7:0]  rs232in_data,
    input  logic        rs232out_busy,
    output logic        rs232out_w,
    output logic [7:0]  rs232out_d,
    output logic        irq
);

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_DATA   = 3'd1;
    localparam logic [2:0] A_RXCNT  = 3'd2;
    localparam logic [2:0] A_TSC    = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_FULL_LVL = RX_DEPTH[RX_AW:0];
    localparam logic [TX_AW:0] TX_FULL_LVL = TX_DEPTH[TX_AW:0];

    logic [2:0] sel;
    logic       unused;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wp, rx_rp;
    logic [RX_AW:0]   rx_level;
    logic             rx_empty, rx_full, rx_push, rx_pop, rx_drop;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wp, tx_rp;
    logic [TX_AW:0]   tx_level;
    logic             tx_empty, tx_full, tx_push, tx_pop, tx_drop;

    logic             rx_overrun, tx_overflow, rx_ie, tx_ie;
    logic [7:0]       rxcnt;
    logic [TSC_W-1:0] tsc;
    logic [1:0]       state, state_next;
    logic [31:0]      status, rd_value;
    logic             tx_ready;

    assign sel      = req_a[4:2];
    assign unused   = &{1'b0, req_a[31:5], req_a[1:0], req_wd[31:8], req_wd[3:2]};
    assign res_hold = 1'b0;

    // A read that coincides with a write keeps the pre-write value and has no pop.
    assign rx_empty = (rx_level == '0);
    assign rx_full  = (rx_level == RX_FULL_LVL);
    assign rx_pop   = req_r & ~req_w & (sel == A_DATA) & ~rx_empty;
    assign rx_push  = rs232in_attention & (~rx_full | rx_pop);
    assign rx_drop  = rs232in_attention & rx_full & ~rx_pop;

    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == TX_FULL_LVL);
    assign tx_pop   = (state == ST_SEND) & ~tx_empty;
    assign tx_push  = req_w & (sel == A_DATA) & (~tx_full | tx_pop);
    assign tx_drop  = req_w & (sel == A_DATA) & tx_full & ~tx_pop;

    assign tx_ready   = ~tx_empty & ~rs232out_busy;
    assign rs232out_w = tx_pop;
    assign rs232out_d = tx_empty ? 8'h00 : tx_mem[tx_rp];

    // RX byte storage (contents need no reset; pointers qualify them).
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rs232in_data;
    end

    // TX byte storage.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= req_wd[7:0];
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + (RX_AW+1)'(1);
                2'b01:   rx_level <= rx_level - (RX_AW+1)'(1);
                default: rx_level <= rx_level;
            endcase
        end
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + (TX_AW+1)'(1);
                2'b01:   tx_level <= tx_level - (TX_AW+1)'(1);
                default: tx_level <= tx_level;
            endcase
        end
    end

    // Sticky error flags (a set in the same cycle beats a clear), control, counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            rx_ie       <= 1'b0;
            tx_ie       <= 1'b0;
            rxcnt       <= '0;
            tsc         <= '0;
        end else begin
            if (rx_drop)
                rx_overrun <= 1'b1;
            else if (req_w && sel == A_STATUS && req_wd[4])
                rx_overrun <= 1'b0;
            if (tx_drop)
                tx_overflow <= 1'b1;
            else if (req_w && sel == A_STATUS && req_wd[5])
                tx_overflow <= 1'b0;
            if (req_w && sel == A_CTRL) begin
                rx_ie <= req_wd[0];
                tx_ie <= req_wd[1];
            end
            if (rs232in_attention) rxcnt <= rxcnt + 8'd1;
            tsc <= tsc + TSC_W'(1);
        end
    end

    // TX drain sequencing; the gap cycle doubles as the idle decision point so
    // back-to-back bytes leave exactly one strobe-free cycle between them.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (tx_ready) state_next = ST_SEND;
            ST_SEND: state_next = ST_GAP;
            ST_GAP:  state_next = tx_ready ? ST_SEND : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Register read multiplexer.
    always_comb begin
        status = {8'h00, 8'(tx_level), 8'(rx_level), 2'b00,
                  tx_overflow, rx_overrun, rx_full, rx_empty, tx_empty, tx_full};
        rd_value = 32'h0;
        case (sel)
            A_STATUS: rd_value = status;
            A_DATA:   rd_value = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
            A_RXCNT:  rd_value = {24'h0, rxcnt};
            A_TSC:    rd_value = 32'(tsc);
            A_CTRL:   rd_value = {30'h0, tx_ie, rx_ie};
            default:  rd_value = 32'h0;
        endcase
    end

    // Registered read data (zero when no read) and interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_rd <= '0;
            irq    <= 1'b0;
        end else begin
            res_rd <= req_r ? rd_value : 32'h0;
            irq    <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty);
        end
    end

endmodule

// File: tb/tb_rs232_fifo_port.sv
// Scoreboard bench for rs232_fifo_port: reads and TX strobes are checked by
// monitor processes against queues filled when stimulus is issued.
module tb_rs232_fifo_port;

    localparam logic [31:0] A_STATUS = 32'h00;
    localparam logic [31:0] A_DATA   = 32'h04;
    localparam logic [31:0] A_RXCNT  = 32'h08;
    localparam logic [31:0] A_TSC    = 32'h0C;
    localparam logic [31:0] A_CTRL   = 32'h10;

    logic        clk;
    logic        rst;
    logic [31:0] req_a;
    logic        req_r;
    logic        req_w;
    logic [31:0] req_wd;
    logic [31:0] res_rd;
    logic        res_hold;
    logic        rs232in_attention;
    logic [7:0]  rs232in_data;
    logic        rs232out_busy;
    logic        rs232out_w;
    logic [7:0]  rs232out_d;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic rd_pend;

    logic [31:0] rd_exp[$];
    logic [7:0]  tx_exp[$];
    int          strobe_q[$];

    rs232_fifo_port #(.RX_AW(2), .TX_AW(2), .TSC_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_r(req_r), .req_w(req_w), .req_wd(req_wd),
        .res_rd(res_rd), .res_hold(res_hold),
        .rs232in_attention(rs232in_attention), .rs232in_data(rs232in_data),
        .rs232out_busy(rs232out_busy), .rs232out_w(rs232out_w),
        .rs232out_d(rs232out_d), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) rd_pend <= 1'b0;
        else      rd_pend <= req_r;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Read-data monitor.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL res_rd: got %h with no read expected", res_rd);
            end else begin
                chk("res_rd", res_rd, rd_exp.pop_front());
            end
        end else if (res_rd !== 32'h0) begin
            chk("res_rd_idle", res_rd, 32'h0);
        end
    end

    // Transmit strobe monitor.
    always @(negedge clk) begin
        if (rs232out_w === 1'b1) begin
            strobe_q.push_back(cyc);
            if (tx_exp.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_strobe: got byte %h with none expected", rs232out_d);
            end else begin
                chk("tx_byte", {24'h0, rs232out_d}, {24'h0, tx_exp.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        req_a = a; req_r = 1'b1; rd_exp.push_back(exp);
        @(negedge clk);
        req_r = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req_a = a; req_wd = d; req_w = 1'b1;
        @(negedge clk);
        req_w = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        req_a = a; req_wd = d; req_w = 1'b1; req_r = 1'b1; rd_exp.push_back(exp);
        @(negedge clk);
        req_w = 1'b0; req_r = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rs232in_data = b; rs232in_attention = 1'b1;
        @(negedge clk);
        rs232in_attention = 1'b0;
    endtask

    task automatic rx_rd(input logic [7:0] b, input logic [31:0] a, input logic [31:0] exp);
        rs232in_data = b; rs232in_attention = 1'b1;
        req_a = a; req_r = 1'b1; rd_exp.push_back(exp);
        @(negedge clk);
        rs232in_attention = 1'b0; req_r = 1'b0;
    endtask

    task automatic rx_wr(input logic [7:0] b, input logic [31:0] a, input logic [31:0] d);
        rs232in_data = b; rs232in_attention = 1'b1;
        req_a = a; req_wd = d; req_w = 1'b1;
        @(negedge clk);
        rs232in_attention = 1'b0; req_w = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int bound, input string name);
        int i;
        i = 0;
        while (strobe_q.size() < n && i < bound) begin
            @(negedge clk);
            #1;
            i++;
        end
        tests++;
        if (strobe_q.size() < n) begin
            fails++;
            $display("FAIL %s: got %0d strobes expected %0d", name, strobe_q.size(), n);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req_a = '0; req_r = 1'b0; req_w = 1'b0; req_wd = '0;
        rs232in_attention = 1'b0; rs232in_data = '0; rs232out_busy = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_w", {31'h0, rs232out_w}, 32'h0);
        chk("rst_d", {24'h0, rs232out_d}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_hold", {31'h0, res_hold}, 32'h0);
        rst = 1'b1;
        rd(A_TSC, 32'd0);
        rd(A_TSC, 32'd1);
        rd(A_STATUS, 32'h6);

        // TX ordering with one idle cycle between strobes
        tx_exp.push_back(8'h41); wr(A_DATA, 32'h41);
        tx_exp.push_back(8'h42); wr(A_DATA, 32'h42);
        tx_exp.push_back(8'h43); wr(A_DATA, 32'h43);
        wait_strobes(3, 20, "tx_order_timeout");
        if (strobe_q.size() >= 3) begin
            chk("tx_spacing_1", 32'(strobe_q[1] - strobe_q[0]), 32'd2);
            chk("tx_spacing_2", 32'(strobe_q[2] - strobe_q[1]), 32'd2);
        end
        repeat (2) @(negedge clk);
        rd(A_STATUS, 32'h6);

        // Busy back-pressure and TX overflow
        strobe_q.delete();
        rs232out_busy = 1'b1;
        tx_exp.push_back(8'h51); wr(A_DATA, 32'h51);
        tx_exp.push_back(8'h52); wr(A_DATA, 32'h52);
        repeat (4) @(negedge clk);
        chk("busy_no_strobe", 32'(strobe_q.size()), 32'd0);
        tx_exp.push_back(8'h53); wr(A_DATA, 32'h53);
        tx_exp.push_back(8'h54); wr(A_DATA, 32'h54);
        wr(A_DATA, 32'h55);
        rd(A_STATUS, 32'h0004_0025);
        begin
            int rel;
            rs232out_busy = 1'b0;
            rel = cyc;
            wait_strobes(1, 5, "busy_release_timeout");
            if (strobe_q.size() >= 1)
                chk("busy_release_lat", 32'(strobe_q[0] - rel), 32'd1);
        end
        wait_strobes(4, 20, "busy_drain_timeout");
        wr(A_STATUS, 32'h20);
        rd(A_STATUS, 32'h6);

        // RX overrun
        for (int i = 1; i <= 5; i++) rx(8'(i));
        rd(A_STATUS, 32'h0000_041A);
        rd(A_RXCNT, 32'd5);
        for (int i = 1; i <= 4; i++) rd(A_DATA, 32'(i));
        rd(A_DATA, 32'h0);
        rd(A_STATUS, 32'h16);
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, 32'h6);

        // Simultaneous push/pop on a full RX FIFO
        rx(8'h11); rx(8'h22); rx(8'h33); rx(8'h44);
        rx_rd(8'h99, A_DATA, 32'h11);
        rd(A_STATUS, 32'h0000_040A);
        rd(A_DATA, 32'h22);
        rd(A_DATA, 32'h33);
        rd(A_DATA, 32'h44);
        rd(A_DATA, 32'h99);
        rd(A_STATUS, 32'h6);

        // Simultaneous push/pop on an empty RX FIFO
        rx_rd(8'h5A, A_DATA, 32'h0);
        rd(A_STATUS, 32'h0000_0102);
        rd(A_RXCNT, 32'd11);
        rd(A_DATA, 32'h5A);
        rd(A_STATUS, 32'h6);

        // Read and write of the same register in one cycle
        rw(A_CTRL, 32'h1, 32'h0);
        rd(A_CTRL, 32'h1);

        // Interrupt follows RX occupancy
        chk("irq_idle", {31'h0, irq}, 32'h0);
        rx(8'h77);
        @(negedge clk);
        chk("irq_set", {31'h0, irq}, 32'h1);
        rd(A_DATA, 32'h77);
        chk("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_clear", {31'h0, irq}, 32'h0);

        // Sticky flags: set beats clear, then a combined clear
        rs232out_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_exp.push_back(8'(8'h81 + i));
            wr(A_DATA, 32'(8'h81 + i));
        end
        wr(A_DATA, 32'h85);
        for (int i = 0; i < 5; i++) rx(8'(8'hA1 + i));
        rd(A_STATUS, 32'h0004_0439);
        rx_wr(8'hA6, A_STATUS, 32'h10);
        rd(A_STATUS, 32'h0004_0439);
        wr(A_STATUS, 32'h30);
        rd(A_STATUS, 32'h0004_0409);
        chk("irq_rx_pending", {31'h0, irq}, 32'h1);

        tx_exp.delete();
        strobe_q.delete();
        do_reset();
        rd(A_STATUS, 32'h6);

        // Reset while a byte is being sent
        tx_exp.push_back(8'h61); wr(A_DATA, 32'h61);
        tx_exp.push_back(8'h62); wr(A_DATA, 32'h62);
        tx_exp.push_back(8'h63); wr(A_DATA, 32'h63);
        rs232out_busy = 1'b0;
        @(negedge clk);
        #2;
        chk("send_active", {31'h0, rs232out_w}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_abort_w", {31'h0, rs232out_w}, 32'h0);
        chk("rst_abort_d", {24'h0, rs232out_d}, 32'h0);
        tx_exp.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd(A_TSC, 32'd0);
        rd(A_STATUS, 32'h6);
        repeat (6) @(negedge clk);
        chk("no_strobe_after_rst", 32'(strobe_q.size()), 32'd1);

        repeat (2) @(negedge clk);
        chk("rd_queue_drained", 32'(rd_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
